// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: width limit and width clamp shared by the pulse_generator slice.
package pulse_gen_pkg;
   localparam int PULSE_GEN_MAX_WIDTH = 64;
   function automatic int pulse_gen_width(input int w);
      return (w < 2) ? 1 : (w > PULSE_GEN_MAX_WIDTH) ? PULSE_GEN_MAX_WIDTH : w;
   endfunction
endpackage

// File: rtl/pulse_gen_edge_det.sv
// pulse_gen_edge_det: rising-edge detector on trigger; PULSE_GEN_SYNC_EN adds a 2-flop synchronizer.
module pulse_gen_edge_det
   import pulse_gen_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic trigger,
   output logic rise
);
   logic trig_s;
   logic trig_d_q, trig_d_d;
`ifdef PULSE_GEN_SYNC_EN
   logic [1:0] sync_q, sync_d;
   always_comb begin
      sync_d = {sync_q[0], trigger};
      trig_s = sync_q[1];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync_q <= '0;
      else        sync_q <= sync_d;
`else
   always_comb trig_s = trigger;
`endif
   // history resets low so a trigger already high at release counts as a rise
   always_comb begin
      trig_d_d = trig_s;
      rise     = trig_s & ~trig_d_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) trig_d_q <= 1'b0;
      else        trig_d_q <= trig_d_d;
endmodule

// File: rtl/pulse_generator.sv
// pulse_generator: turns a trigger rising edge into a PULSE_WIDTH-cycle one-shot.
// Build option PULSE_GEN_SYNC_EN synchronizes trigger first (3-edge latency).
module pulse_generator
   import pulse_gen_pkg::*;
#(
   parameter int PULSE_WIDTH = 4,
   parameter int RETRIGGER   = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic trigger,
   output logic pulse
);
   localparam int W = pulse_gen_width(PULSE_WIDTH);
   logic         rise;
   logic [W-1:0] shift_reg_q, shift_reg_d;
   pulse_gen_edge_det u_edge (
      .clk     (clk),
      .rst_n   (rst_n),
      .trigger (trigger),
      .rise    (rise)
   );
   // a rise while draining is dropped unless retriggering is enabled
   always_comb
      shift_reg_d = (rise && (shift_reg_q == '0 || RETRIGGER != 0)) ? {W{1'b1}} : shift_reg_q >> 1;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) shift_reg_q <= '0;
      else        shift_reg_q <= shift_reg_d;
   assign pulse = shift_reg_q[0];
endmodule

// File: tb/tb_pulse_generator.sv
// tb_pulse_generator: scoreboard bench for pulse_generator, one-shot and retriggering instances.
module tb_pulse_generator;
   localparam int W = 4;
   typedef struct {
      logic         p;
      logic         prt;
      logic [W-1:0] sr;
   } exp_t;
   logic clk = 1'b0, rst_n = 1'b0, trigger = 1'b0;
   logic pulse, pulse_rt;
   int   total = 0, bad = 0;
   int   rem = 0, rem_rt = 0, hi = 0, hi_rt = 0;
   logic prev = 1'b0, s0 = 1'b0, s1 = 1'b0;
   exp_t sb[$];
   always #5 clk = ~clk;
   pulse_generator #(.PULSE_WIDTH(W), .RETRIGGER(0)) dut (
      .clk(clk), .rst_n(rst_n), .trigger(trigger), .pulse(pulse));
   pulse_generator #(.PULSE_WIDTH(W), .RETRIGGER(1)) dut_rt (
      .clk(clk), .rst_n(rst_n), .trigger(trigger), .pulse(pulse_rt));
   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask
   task automatic model_reset();
      rem = 0; rem_rt = 0; prev = 1'b0; s0 = 1'b0; s1 = 1'b0;
   endtask
   task automatic model_push(input logic t);
      logic ts, r;
      exp_t e;
`ifdef PULSE_GEN_SYNC_EN
      ts = s1; s1 = s0; s0 = t;
`else
      ts = t;
`endif
      r = ts & ~prev;
      prev = ts;
      rem    = (r && rem == 0) ? W : (rem > 0 ? rem - 1 : 0);
      rem_rt = r ? W : (rem_rt > 0 ? rem_rt - 1 : 0);
      e.p = rem > 0;
      e.prt = rem_rt > 0;
      e.sr = '0;
      for (int i = 0; i < rem; i++) e.sr[i] = 1'b1;
      sb.push_back(e);
   endtask
   task automatic cyc(input logic t);
      exp_t e;
      trigger = t;
      model_push(t);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("pulse", pulse, e.p);
      check("pulse_rt", pulse_rt, e.prt);
      check("shift_reg", dut.shift_reg_q, e.sr);
      if (pulse) hi++;
      if (pulse_rt) hi_rt++;
   endtask
   initial begin
      #12;
      check("reset_pulse", pulse, 0);
      check("reset_shift", dut.shift_reg_q, 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) cyc(0);
      hi = 0;
      cyc(1);
      repeat (6) cyc(0);
      check("single_width", hi, 4);
      hi = 0;
      repeat (10) cyc(1);
      repeat (3) cyc(0);
      check("held_width", hi, 4);
      cyc(1);
      repeat (6) cyc(0);
      hi = 0;
      cyc(1);
      repeat (5) cyc(0);
      cyc(1);
      repeat (6) cyc(0);
      check("two_events", hi, 8);
      hi = 0; hi_rt = 0;
      cyc(1); cyc(0); cyc(1);
      repeat (8) cyc(0);
      check("retrig0_width", hi, 4);
      check("retrig1_width", hi_rt, 6);
      hi = 0;
      cyc(1);
      repeat (3) cyc(0);
      cyc(1);
      repeat (6) cyc(0);
      check("last_cycle_rise", hi, 4);
      hi = 0;
      cyc(1);
      repeat (4) cyc(0);
      cyc(1);
      repeat (6) cyc(0);
      check("after_fall_rise", hi, 8);
      cyc(1);
      cyc(0);
`ifdef PULSE_GEN_SYNC_EN
      cyc(0);
      cyc(0);
`endif
      check("pre_reset_high", pulse, 1);
      @(negedge clk);
      rst_n = 1'b0;
      trigger = 1'b1;
      model_reset();
      #1;
      check("async_pulse", pulse, 0);
      check("async_pulse_rt", pulse_rt, 0);
      @(negedge clk) rst_n = 1'b1;
      hi = 0;
      cyc(1);
      repeat (8) cyc(0);
      check("rise_after_reset", hi, 4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
